// File: rtl/mmio_bridge_pkg.sv
// Shared types and default address map for the MMIO bridge.
//   state_t       : bridge FSM states
//   DEF_*         : default channel windows and write restrictions
//   DEV_*         : channel index names
//   idx_width()   : width of a channel index for a given channel count
package mmio_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        ERR
    } state_t;

    localparam int DEF_NUM_DEV = 3;

    // Channel i occupies bits [i*32 +: 32].
    localparam logic [3*32-1:0] DEF_DEV_BASE = {32'h7f10, 32'h7f00, 32'h0000};
    localparam logic [3*32-1:0] DEF_DEV_SIZE = {32'h000c, 32'h000c, 32'h3000};
    localparam logic [2:0]      DEF_WORD_ONLY_MASK = 3'b110;

    localparam int DEV_DM  = 0;
    localparam int DEV_TC0 = 1;
    localparam int DEV_TC1 = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Bus bundle between the CPU data port, the bridge and its slaves.
//   slave modport  : the bridge's view (takes CPU requests and slave acks)
//   master modport : the environment's view (CPU plus slaves)
interface mmio_bridge_if #(
    parameter int NUM_DEV = 3,
    parameter int DW      = 32,
    parameter int AW      = 32
);
    logic                  cpu_req;
    logic [AW-1:0]         cpu_addr;
    logic [DW-1:0]         cpu_wdata;
    logic [DW/8-1:0]       cpu_byteen;
    logic                  cpu_ready;
    logic [DW-1:0]         cpu_rdata;
    logic                  cpu_err;
    logic [AW-1:0]         err_addr;
    logic [NUM_DEV-1:0]    dev_sel;
    logic [AW-1:0]         dev_addr;
    logic [DW-1:0]         dev_wdata;
    logic [DW/8-1:0]       dev_byteen;
    logic [NUM_DEV-1:0]    dev_ack;
    logic [NUM_DEV*DW-1:0] dev_rdata;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen, dev_ack, dev_rdata,
        output cpu_ready, cpu_rdata, cpu_err, err_addr,
               dev_sel, dev_addr, dev_wdata, dev_byteen
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_byteen, dev_ack, dev_rdata,
        input  cpu_ready, cpu_rdata, cpu_err, err_addr,
               dev_sel, dev_addr, dev_wdata, dev_byteen
    );

endinterface

// File: rtl/mmio_addr_decoder.sv
// Combinational address decoder for the MMIO bridge.
//   addr    : request byte address
//   byteen  : request byte enables (zero means read)
//   hit     : one-hot matching channel, lowest index wins on overlap
//   hit_idx : binary index of hit
//   illegal : no window matched, or a partial write to a word-only channel
module mmio_addr_decoder
    import mmio_bridge_pkg::*;
#(
    parameter int                     NUM_DEV        = DEF_NUM_DEV,
    parameter int                     DW             = 32,
    parameter int                     AW             = 32,
    parameter logic [NUM_DEV*AW-1:0]  DEV_BASE       = DEF_DEV_BASE,
    parameter logic [NUM_DEV*AW-1:0]  DEV_SIZE       = DEF_DEV_SIZE,
    parameter logic [NUM_DEV-1:0]     WORD_ONLY_MASK = DEF_WORD_ONLY_MASK,
    parameter int                     IDX_W          = idx_width(NUM_DEV)
) (
    input  logic [AW-1:0]      addr,
    input  logic [DW/8-1:0]    byteen,
    output logic [NUM_DEV-1:0] hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               illegal
);

    logic [NUM_DEV-1:0] in_win;

    // One extra bit keeps base + size - 1 from wrapping at the top of the map.
    for (genvar i = 0; i < NUM_DEV; i++) begin : g_win
        logic [AW:0] base_x;
        logic [AW:0] size_x;
        logic [AW:0] last_x;
        assign base_x    = {1'b0, DEV_BASE[i*AW +: AW]};
        assign size_x    = {1'b0, DEV_SIZE[i*AW +: AW]};
        assign last_x    = base_x + size_x - (AW+1)'(1);
        assign in_win[i] = (size_x != '0) && ({1'b0, addr} >= base_x) && ({1'b0, addr} <= last_x);
    end

    always_comb begin
        hit     = '0;
        hit_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (in_win[i]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        illegal = (hit == '0) ||
                  ((byteen != '0) && (|(hit & WORD_ONLY_MASK)) && (byteen != '1));
    end

endmodule

// File: rtl/mmio_bridge.sv
// Handshaked MMIO bridge: routes one CPU request at a time to the slave
// whose window contains the address, waits for its ack and returns a
// registered one-cycle ready/error response.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mmio_bridge_if.slave (CPU request/response, slave select,
//                broadcast address/data/byte enables, per-slave ack/rdata,
//                err_addr of the last errored access)
// Build option: BRIDGE_TIMEOUT_EN adds a WAIT-state limit of TIMEOUT_CYCLES
// cycles, after which the access is terminated with an error.
//
// state | meaning
// IDLE  | accept and decode a request
// WAIT  | slave selected, waiting for its ack
// RESP  | cpu_ready pulse with read data
// ERR   | cpu_ready + cpu_err pulse, err_addr updated on exit
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int                     NUM_DEV        = DEF_NUM_DEV,
    parameter int                     DW             = 32,
    parameter int                     AW             = 32,
    parameter logic [NUM_DEV*AW-1:0]  DEV_BASE       = DEF_DEV_BASE,
    parameter logic [NUM_DEV*AW-1:0]  DEV_SIZE       = DEF_DEV_SIZE,
    parameter logic [NUM_DEV-1:0]     WORD_ONLY_MASK = DEF_WORD_ONLY_MASK
`ifdef BRIDGE_TIMEOUT_EN
    ,
    parameter int                     TIMEOUT_CYCLES = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    mmio_bridge_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_DEV);

    state_t             state;
    logic [NUM_DEV-1:0] dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               dec_illegal;
    logic [IDX_W-1:0]   sel_idx;
    logic [AW-1:0]      cap_addr;
    logic               ack_sel;
    logic [DW-1:0]      rdata_sel;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`endif

    mmio_addr_decoder #(
        .NUM_DEV        (NUM_DEV),
        .DW             (DW),
        .AW             (AW),
        .DEV_BASE       (DEV_BASE),
        .DEV_SIZE       (DEV_SIZE),
        .WORD_ONLY_MASK (WORD_ONLY_MASK),
        .IDX_W          (IDX_W)
    ) u_dec (
        .addr    (bus.cpu_addr),
        .byteen  (bus.cpu_byteen),
        .hit     (dec_hit),
        .hit_idx (dec_idx),
        .illegal (dec_illegal)
    );

    // Acks from unselected slaves are masked off by the held select.
    assign ack_sel   = |(bus.dev_ack & bus.dev_sel);
    assign rdata_sel = bus.dev_rdata[sel_idx*DW +: DW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sel_idx        <= '0;
            cap_addr       <= '0;
            bus.cpu_ready  <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_err    <= 1'b0;
            bus.err_addr   <= '0;
            bus.dev_sel    <= '0;
            bus.dev_addr   <= '0;
            bus.dev_wdata  <= '0;
            bus.dev_byteen <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        cap_addr <= bus.cpu_addr;
                        if (dec_illegal) begin
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_err   <= 1'b1;
                            bus.cpu_rdata <= '0;
                            state         <= ERR;
                        end else begin
                            sel_idx        <= dec_idx;
                            bus.dev_sel    <= dec_hit;
                            bus.dev_addr   <= bus.cpu_addr;
                            bus.dev_wdata  <= bus.cpu_wdata;
                            bus.dev_byteen <= bus.cpu_byteen;
`ifdef BRIDGE_TIMEOUT_EN
                            wait_cnt       <= '0;
`endif
                            state          <= WAIT;
                        end
                    end
                end
                WAIT: begin
`ifdef BRIDGE_TIMEOUT_EN
                    wait_cnt <= wait_cnt + TW'(1);
`endif
                    if (ack_sel) begin
                        bus.cpu_rdata <= (bus.dev_byteen != '0) ? '0 : rdata_sel;
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_err   <= 1'b0;
                        bus.dev_sel   <= '0;
                        state         <= RESP;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    // wait_cnt + 1 is the number of WAIT cycles spent including this one.
                    else if (wait_cnt + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
                        bus.cpu_rdata <= '0;
                        bus.cpu_ready <= 1'b1;
                        bus.cpu_err   <= 1'b1;
                        bus.dev_sel   <= '0;
                        state         <= ERR;
                    end
`endif
                end
                RESP: begin
                    bus.cpu_ready <= 1'b0;
                    state         <= IDLE;
                end
                ERR: begin
                    bus.cpu_ready <= 1'b0;
                    bus.cpu_err   <= 1'b0;
                    bus.err_addr  <= cap_addr;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
